// File: rtl/tl_ul_arbiter.sv
// tl_ul_arbiter: two-master to one-slave TileLink-UL arbiter, one transaction in flight at a time.
//
// Optional feature macro: TL_ARB_TIMEOUT_EN. When it is defined, a WAIT_D watchdog answers the granted
// master with a synthetic AccessAck/AccessAckData after TIMEOUT_CYCLES silent cycles.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   m0_a_*, m1_a_*    requester A channels (valid/opcode/size/source/address/mask/data in, ready out)
//   m0_d_*, m1_d_*    requester D channels (valid/opcode/source/data out, ready in)
//   s_a_*             slave A channel (s_a_ready in, everything else out)
//   s_d_*             slave D channel (s_d_ready out, everything else in)
//   busy              high whenever the arbiter is not IDLE
//   grant_id          granted (or last granted) master index
//   timeout_err       one-cycle pulse when the watchdog expires (always 0 without TL_ARB_TIMEOUT_EN)
module tl_ul_arbiter #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TL_SIZE_BITS   = 3,
    parameter int TL_SOURCE_BITS = 8,
    parameter int TL_ADDR_BITS   = 32,
    parameter int TL_DATA_BYTES  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m0_a_valid,
    output logic                         m0_a_ready,
    input  logic [2:0]                   m0_a_opcode,
    input  logic [TL_SIZE_BITS-1:0]      m0_a_size,
    input  logic [TL_SOURCE_BITS-1:0]    m0_a_source,
    input  logic [TL_ADDR_BITS-1:0]      m0_a_address,
    input  logic [TL_DATA_BYTES-1:0]     m0_a_mask,
    input  logic [TL_DATA_BYTES*8-1:0]   m0_a_data,
    output logic                         m0_d_valid,
    input  logic                         m0_d_ready,
    output logic [2:0]                   m0_d_opcode,
    output logic [TL_SOURCE_BITS-1:0]    m0_d_source,
    output logic [TL_DATA_BYTES*8-1:0]   m0_d_data,
    input  logic                         m1_a_valid,
    output logic                         m1_a_ready,
    input  logic [2:0]                   m1_a_opcode,
    input  logic [TL_SIZE_BITS-1:0]      m1_a_size,
    input  logic [TL_SOURCE_BITS-1:0]    m1_a_source,
    input  logic [TL_ADDR_BITS-1:0]      m1_a_address,
    input  logic [TL_DATA_BYTES-1:0]     m1_a_mask,
    input  logic [TL_DATA_BYTES*8-1:0]   m1_a_data,
    output logic                         m1_d_valid,
    input  logic                         m1_d_ready,
    output logic [2:0]                   m1_d_opcode,
    output logic [TL_SOURCE_BITS-1:0]    m1_d_source,
    output logic [TL_DATA_BYTES*8-1:0]   m1_d_data,
    output logic                         s_a_valid,
    input  logic                         s_a_ready,
    output logic [2:0]                   s_a_opcode,
    output logic [TL_SIZE_BITS-1:0]      s_a_size,
    output logic [TL_SOURCE_BITS-1:0]    s_a_source,
    output logic [TL_ADDR_BITS-1:0]      s_a_address,
    output logic [TL_DATA_BYTES-1:0]     s_a_mask,
    output logic [TL_DATA_BYTES*8-1:0]   s_a_data,
    input  logic                         s_d_valid,
    output logic                         s_d_ready,
    input  logic [2:0]                   s_d_opcode,
    input  logic [TL_SOURCE_BITS-1:0]    s_d_source,
    input  logic [TL_DATA_BYTES*8-1:0]   s_d_data,
    output logic                         busy,
    output logic                         grant_id,
    output logic                         timeout_err
);
    localparam int DW = TL_DATA_BYTES * 8;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("tl_ul_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, A_SEND, WAIT_D} state_t;

    state_t r_state;
    logic   r_grant;
    logic   r_rr_ptr;

    logic            w_idle;
    logic            w_asend;
    logic            w_waitd;
    logic            w_win;
    logic            w_a_valid;
    logic            w_d_ready;
    logic            w_d_valid;
    logic            w_d_fire;
    logic            w_syn;
    logic [2:0]      w_d_opcode;
    logic [TL_SOURCE_BITS-1:0] w_d_source;
    logic [DW-1:0]   w_d_data;

    assign w_idle  = (r_state == IDLE);
    assign w_asend = (r_state == A_SEND);
    assign w_waitd = (r_state == WAIT_D);

    // A lone requester always wins; on a tie the fixed mode favours m0 and round-robin favours rr_ptr.
    assign w_win = (PRIORITY_MODE != 0 || !(m0_a_valid && m1_a_valid)) ? ~m0_a_valid : r_rr_ptr;

    // The A mux follows grant_id in every state; only s_a_valid is gated by the state.
    assign w_a_valid   = r_grant ? m1_a_valid   : m0_a_valid;
    assign s_a_valid   = w_asend & w_a_valid;
    assign s_a_opcode  = r_grant ? m1_a_opcode  : m0_a_opcode;
    assign s_a_size    = r_grant ? m1_a_size    : m0_a_size;
    assign s_a_source  = r_grant ? m1_a_source  : m0_a_source;
    assign s_a_address = r_grant ? m1_a_address : m0_a_address;
    assign s_a_mask    = r_grant ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = r_grant ? m1_a_data    : m0_a_data;
    assign m0_a_ready  = w_asend & ~r_grant & s_a_ready;
    assign m1_a_ready  = w_asend &  r_grant & s_a_ready;

    // D routing is decided by grant_id alone; d_source is never inspected.
    assign w_d_ready  = r_grant ? m1_d_ready : m0_d_ready;
    assign w_d_valid  = w_waitd & (w_syn | s_d_valid);
    assign w_d_fire   = w_d_valid & w_d_ready;
    assign m0_d_valid = w_d_valid & ~r_grant;
    assign m1_d_valid = w_d_valid &  r_grant;
    assign m0_d_opcode = w_d_opcode;
    assign m1_d_opcode = w_d_opcode;
    assign m0_d_source = w_d_source;
    assign m1_d_source = w_d_source;
    assign m0_d_data   = w_d_data;
    assign m1_d_data   = w_d_data;

    // IDLE sinks stray slave responses, but ready is held low while reset is asserted.
    assign s_d_ready = w_idle ? rst_n : (w_waitd & ~w_syn & w_d_ready);

    assign busy     = ~w_idle;
    assign grant_id = r_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_a_valid || m1_a_valid) begin
                        r_grant <= w_win;
                        r_state <= A_SEND;
                    end
                end
                A_SEND: begin
                    // A granted master withdrawing its request abandons the grant without issuing a beat.
                    if (!w_a_valid)
                        r_state <= IDLE;
                    else if (s_a_ready)
                        r_state <= WAIT_D;
                end
                WAIT_D: begin
                    if (w_d_fire) begin
                        r_state <= IDLE;
                        if (PRIORITY_MODE == 0)
                            r_rr_ptr <= ~r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]             r_cnt;
    logic                      r_to_err;
    logic                      r_get;
    logic [TL_SOURCE_BITS-1:0] r_src;

    // Once the count saturates at the limit the arbiter answers on the slave's behalf.
    assign w_syn       = w_waitd & (r_cnt == TO_LIM);
    assign w_d_opcode  = w_syn ? (r_get ? 3'd1 : 3'd0) : s_d_opcode;
    assign w_d_source  = w_syn ? r_src : s_d_source;
    assign w_d_data    = w_syn ? '0 : s_d_data;
    assign timeout_err = r_to_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
            r_get    <= 1'b0;
            r_src    <= '0;
        end else begin
            r_to_err <= w_waitd & ~w_d_fire & (r_cnt == TO_LAST);
            if (s_a_valid && s_a_ready) begin
                r_cnt <= '0;
                r_get <= (s_a_opcode == 3'd4);
                r_src <= s_a_source;
            end else if (w_waitd && !w_d_fire && !w_syn) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_syn       = 1'b0;
    assign w_d_opcode  = s_d_opcode;
    assign w_d_source  = s_d_source;
    assign w_d_data    = s_d_data;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// tb_tl_ul_arbiter: self-checking bench for tl_ul_arbiter (round-robin and fixed-priority instances).
module tb_tl_ul_arbiter;
    localparam int SB = 3;
    localparam int IB = 8;
    localparam int AB = 32;
    localparam int DB = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_valid [2];
    logic [2:0]    a_opcode [2];
    logic [SB-1:0] a_size [2];
    logic [IB-1:0] a_source [2];
    logic [AB-1:0] a_addr [2];
    logic [DB-1:0] a_mask [2];
    logic [DW-1:0] a_data [2];
    logic          d_ready [2];
    logic          s_a_ready, s_d_valid;
    logic [2:0]    s_d_opcode;
    logic [IB-1:0] s_d_source;
    logic [DW-1:0] s_d_data;

    logic          a_ready [2], d_valid [2];
    logic [2:0]    d_opcode [2];
    logic [IB-1:0] d_source [2];
    logic [DW-1:0] d_data [2];
    logic          sa_valid, sd_ready, busy, grant_id, timeout_err;
    logic [2:0]    sa_opcode;
    logic [SB-1:0] sa_size;
    logic [IB-1:0] sa_source;
    logic [AB-1:0] sa_addr;
    logic [DB-1:0] sa_mask;
    logic [DW-1:0] sa_data;

    logic          fp_a_ready [2], fp_d_valid [2];
    logic [2:0]    fp_d_opcode [2];
    logic [IB-1:0] fp_d_source [2];
    logic [DW-1:0] fp_d_data [2];
    logic          fp_sa_valid, fp_sd_ready, fp_busy, fp_grant_id, fp_timeout_err;
    logic [2:0]    fp_sa_opcode;
    logic [SB-1:0] fp_sa_size;
    logic [IB-1:0] fp_sa_source;
    logic [AB-1:0] fp_sa_addr;
    logic [DB-1:0] fp_sa_mask;
    logic [DW-1:0] fp_sa_data;

    int vectors = 0;
    int errors = 0;
    bit pend [2];
    int rr;

    tl_ul_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8), .TL_SIZE_BITS(SB), .TL_SOURCE_BITS(IB),
                    .TL_ADDR_BITS(AB), .TL_DATA_BYTES(DB)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_a_valid(a_valid[0]), .m0_a_ready(a_ready[0]), .m0_a_opcode(a_opcode[0]), .m0_a_size(a_size[0]),
        .m0_a_source(a_source[0]), .m0_a_address(a_addr[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
        .m0_d_valid(d_valid[0]), .m0_d_ready(d_ready[0]), .m0_d_opcode(d_opcode[0]), .m0_d_source(d_source[0]),
        .m0_d_data(d_data[0]),
        .m1_a_valid(a_valid[1]), .m1_a_ready(a_ready[1]), .m1_a_opcode(a_opcode[1]), .m1_a_size(a_size[1]),
        .m1_a_source(a_source[1]), .m1_a_address(a_addr[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
        .m1_d_valid(d_valid[1]), .m1_d_ready(d_ready[1]), .m1_d_opcode(d_opcode[1]), .m1_d_source(d_source[1]),
        .m1_d_data(d_data[1]),
        .s_a_valid(sa_valid), .s_a_ready(s_a_ready), .s_a_opcode(sa_opcode), .s_a_size(sa_size),
        .s_a_source(sa_source), .s_a_address(sa_addr), .s_a_mask(sa_mask), .s_a_data(sa_data),
        .s_d_valid(s_d_valid), .s_d_ready(sd_ready), .s_d_opcode(s_d_opcode), .s_d_source(s_d_source),
        .s_d_data(s_d_data), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    tl_ul_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8), .TL_SIZE_BITS(SB), .TL_SOURCE_BITS(IB),
                    .TL_ADDR_BITS(AB), .TL_DATA_BYTES(DB)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_a_valid(a_valid[0]), .m0_a_ready(fp_a_ready[0]), .m0_a_opcode(a_opcode[0]), .m0_a_size(a_size[0]),
        .m0_a_source(a_source[0]), .m0_a_address(a_addr[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
        .m0_d_valid(fp_d_valid[0]), .m0_d_ready(d_ready[0]), .m0_d_opcode(fp_d_opcode[0]),
        .m0_d_source(fp_d_source[0]), .m0_d_data(fp_d_data[0]),
        .m1_a_valid(a_valid[1]), .m1_a_ready(fp_a_ready[1]), .m1_a_opcode(a_opcode[1]), .m1_a_size(a_size[1]),
        .m1_a_source(a_source[1]), .m1_a_address(a_addr[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
        .m1_d_valid(fp_d_valid[1]), .m1_d_ready(d_ready[1]), .m1_d_opcode(fp_d_opcode[1]),
        .m1_d_source(fp_d_source[1]), .m1_d_data(fp_d_data[1]),
        .s_a_valid(fp_sa_valid), .s_a_ready(s_a_ready), .s_a_opcode(fp_sa_opcode), .s_a_size(fp_sa_size),
        .s_a_source(fp_sa_source), .s_a_address(fp_sa_addr), .s_a_mask(fp_sa_mask), .s_a_data(fp_sa_data),
        .s_d_valid(s_d_valid), .s_d_ready(fp_sd_ready), .s_d_opcode(s_d_opcode), .s_d_source(s_d_source),
        .s_d_data(s_d_data), .busy(fp_busy), .grant_id(fp_grant_id), .timeout_err(fp_timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            a_valid[m] = 1'b0; a_opcode[m] = 3'd4; a_size[m] = '0; a_source[m] = '0;
            a_addr[m] = '0; a_mask[m] = '0; a_data[m] = '0; d_ready[m] = 1'b1; pend[m] = 1'b0;
        end
        s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_opcode = '0; s_d_source = '0; s_d_data = '0;
        rr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic new_req(input int m);
        int op;
        op = $urandom_range(2, 0);
        a_valid[m] = 1'b1;
        a_opcode[m] = (op == 0) ? 3'd4 : 3'(op - 1);
        a_size[m] = 3'($urandom_range(2, 0));
        a_source[m] = 8'($urandom);
        a_addr[m] = $urandom;
        a_mask[m] = 4'($urandom);
        a_data[m] = $urandom;
        pend[m] = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        a_valid[1] = 1'b1; a_source[1] = 8'h21;
        tick();
        s_a_ready = 1'b1;
        tick();
        a_valid[1] = 1'b0; s_a_ready = 1'b0;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (sa_valid !== 1'b0) begin errors++; $display("FAIL rst_sa_valid: got %b want 0", sa_valid); end
        vectors++; if (sd_ready !== 1'b0) begin errors++; $display("FAIL rst_sd_ready: got %b want 0", sd_ready); end
        vectors++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant_id); end
        tick();
        tick();
        vectors++; if ({a_ready[0], a_ready[1], d_valid[0], d_valid[1]} !== 4'b0) begin errors++; $display("FAIL rst_valids: got %b want 0000", {a_ready[0], a_ready[1], d_valid[0], d_valid[1]}); end
        rst_n = 1'b1;
        #1;
        s_d_valid = 1'b1; s_d_source = 8'h21;
        #1;
        vectors++; if (sd_ready !== 1'b1) begin errors++; $display("FAIL rst_stray_ready: got %b want 1", sd_ready); end
        vectors++; if ({d_valid[0], d_valid[1]} !== 2'b00) begin errors++; $display("FAIL rst_stray_dvalid: got %b want 00", {d_valid[0], d_valid[1]}); end
        tick();
        s_d_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_post_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_put();
        do_reset();
        a_valid[0] = 1'b1; a_opcode[0] = 3'd0; a_addr[0] = 32'h40; a_data[0] = 32'hDEADBEEF;
        a_mask[0] = 4'hF; a_size[0] = 3'd2; a_source[0] = 8'h03;
        #1;
        vectors++; if (sa_valid !== 1'b0) begin errors++; $display("FAIL put_early_valid: got %b want 0", sa_valid); end
        tick();
        vectors++; if (sa_valid !== 1'b1) begin errors++; $display("FAIL put_sa_valid: got %b want 1", sa_valid); end
        vectors++; if ({sa_opcode, sa_size, sa_source, sa_addr, sa_mask, sa_data} !== {3'd0, 3'd2, 8'h03, 32'h40, 4'hF, 32'hDEADBEEF})
            begin errors++; $display("FAIL put_fields: got %h %h %h %h %h %h", sa_opcode, sa_size, sa_source, sa_addr, sa_mask, sa_data); end
        s_a_ready = 1'b1;
        #1;
        vectors++; if ({a_ready[0], a_ready[1]} !== 2'b10) begin errors++; $display("FAIL put_a_ready: got %b want 10", {a_ready[0], a_ready[1]}); end
        tick();
        a_valid[0] = 1'b0; s_a_ready = 1'b0;
        s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_source = 8'h03; s_d_data = 32'h0;
        #1;
        vectors++; if ({d_valid[0], d_valid[1]} !== 2'b10) begin errors++; $display("FAIL put_d_route: got %b want 10", {d_valid[0], d_valid[1]}); end
        vectors++; if ({d_opcode[0], d_source[0]} !== {3'd0, 8'h03}) begin errors++; $display("FAIL put_d_fields: got %h %h want 0 03", d_opcode[0], d_source[0]); end
        tick();
        s_d_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL put_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        do_reset();
        for (int m = 0; m < 2; m++) begin
            a_valid[m] = 1'b1; a_opcode[m] = 3'd4; a_source[m] = 8'(m + 1); a_addr[m] = 32'(16 * m);
        end
        s_a_ready = 1'b1; s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_data = 32'h1234_5678;
        for (int t = 0; t < 4; t++) begin
            tick();
            vectors++; if (grant_id !== 1'(t % 2)) begin errors++; $display("FAIL rr_grant%0d: got %b want %0d", t, grant_id, t % 2); end
            vectors++; if (fp_grant_id !== 1'b0) begin errors++; $display("FAIL fp_grant%0d: got %b want 0", t, fp_grant_id); end
            tick();
            vectors++; if ({d_valid[t % 2], d_valid[1 - t % 2]} !== 2'b10) begin errors++; $display("FAIL rr_route%0d: got %b%b", t, d_valid[0], d_valid[1]); end
            vectors++; if ({fp_d_valid[0], fp_d_valid[1]} !== 2'b10) begin errors++; $display("FAIL fp_route%0d: got %b%b want 10", t, fp_d_valid[0], fp_d_valid[1]); end
            tick();
        end
        a_valid[0] = 1'b0;
        tick();
        vectors++; if (fp_grant_id !== 1'b1) begin errors++; $display("FAIL fp_starve_release: got %b want 1", fp_grant_id); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid[1] = 1'b1; a_opcode[1] = 3'd1; a_addr[1] = 32'h0000_0A00; a_data[1] = 32'hCAFE_F00D;
        a_mask[1] = 4'h6; a_source[1] = 8'h7;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if ({sa_valid, a_ready[1], sa_addr, sa_data, sa_mask} !== {1'b1, 1'b0, 32'h0000_0A00, 32'hCAFE_F00D, 4'h6})
                begin errors++; $display("FAIL bp_a_hold%0d: got %b %b %h %h %h", i, sa_valid, a_ready[1], sa_addr, sa_data, sa_mask); end
            tick();
        end
        s_a_ready = 1'b1;
        #1;
        vectors++; if (a_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_a_ready: got %b want 1", a_ready[1]); end
        tick();
        vectors++; if (sa_valid !== 1'b0) begin errors++; $display("FAIL bp_double_fire: got %b want 0", sa_valid); end
        a_valid[1] = 1'b0; s_a_ready = 1'b0;
        s_d_valid = 1'b1; s_d_source = 8'h7; d_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({sd_ready, d_valid[1]} !== 2'b01) begin errors++; $display("FAIL bp_d_hold%0d: got %b%b want 01", i, sd_ready, d_valid[1]); end
            tick();
        end
        d_ready[1] = 1'b1;
        #1;
        vectors++; if (sd_ready !== 1'b1) begin errors++; $display("FAIL bp_d_mirror: got %b want 1", sd_ready); end
        tick();
        s_d_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_violation();
        do_reset();
        a_valid[0] = 1'b1;
        tick();
        a_valid[0] = 1'b0;
        #1;
        vectors++; if (sa_valid !== 1'b0) begin errors++; $display("FAIL viol_sa_valid: got %b want 0", sa_valid); end
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL viol_busy: got %b want 0", busy); end
    endtask

    task automatic test_random();
        int exp;
        logic [2:0] op;
        logic [IB-1:0] src;
        logic [DW-1:0] dat;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(1, 0) == 1) new_req(m);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(1, 0)));
            exp = (pend[0] && pend[1]) ? rr : (pend[0] ? 0 : 1);
            #1;
            vectors++; if ({busy, timeout_err} !== 2'b00) begin errors++; $display("FAIL rnd_idle%0d: got %b%b want 00", n, busy, timeout_err); end
            tick();
            vectors++; if (grant_id !== 1'(exp)) begin errors++; $display("FAIL rnd_grant%0d: got %b want %0d", n, grant_id, exp); end
            vectors++; if ({sa_valid, sa_opcode, sa_size, sa_source, sa_addr, sa_mask, sa_data} !==
                           {1'b1, a_opcode[exp], a_size[exp], a_source[exp], a_addr[exp], a_mask[exp], a_data[exp]})
                begin errors++; $display("FAIL rnd_afields%0d: got %b %h %h %h %h %h", n, sa_valid, sa_opcode, sa_source, sa_addr, sa_mask, sa_data); end
            repeat ($urandom_range(3, 0)) begin
                tick();
                vectors++; if ({sa_valid, a_ready[exp], sa_addr} !== {1'b1, 1'b0, a_addr[exp]}) begin errors++; $display("FAIL rnd_astall%0d: got %b %b %h", n, sa_valid, a_ready[exp], sa_addr); end
            end
            s_a_ready = 1'b1;
            #1;
            vectors++; if ({a_ready[exp], a_ready[1 - exp]} !== 2'b10) begin errors++; $display("FAIL rnd_aready%0d: got %b%b want 10", n, a_ready[exp], a_ready[1 - exp]); end
            tick();
            s_a_ready = 1'b0; a_valid[exp] = 1'b0; pend[exp] = 1'b0;
            d_ready[exp] = 1'b0; d_ready[1 - exp] = 1'($urandom_range(1, 0));
            repeat ($urandom_range(3, 0)) begin
                #1;
                vectors++; if ({d_valid[0], d_valid[1], sa_valid} !== 3'b000) begin errors++; $display("FAIL rnd_dwait%0d: got %b%b%b want 000", n, d_valid[0], d_valid[1], sa_valid); end
                tick();
            end
            op = 3'($urandom_range(1, 0)); src = 8'($urandom); dat = $urandom;
            s_d_valid = 1'b1; s_d_opcode = op; s_d_source = src; s_d_data = dat;
            repeat ($urandom_range(2, 0)) begin
                #1;
                vectors++; if ({d_valid[exp], d_valid[1 - exp], sd_ready, d_data[exp]} !== {3'b100, dat}) begin errors++; $display("FAIL rnd_dstall%0d: got %b%b%b %h want 100 %h", n, d_valid[exp], d_valid[1 - exp], sd_ready, d_data[exp], dat); end
                tick();
            end
            d_ready[exp] = 1'b1;
            #1;
            vectors++; if ({sd_ready, d_valid[exp], d_valid[1 - exp], d_opcode[exp], d_source[exp], d_data[exp]} !== {3'b110, op, src, dat})
                begin errors++; $display("FAIL rnd_dfire%0d: got %b%b%b %h %h %h", n, sd_ready, d_valid[exp], d_valid[1 - exp], d_opcode[exp], d_source[exp], d_data[exp]); end
            tick();
            s_d_valid = 1'b0;
            d_ready[1 - exp] = 1'b1;
            rr = 1 - exp;
        end
    endtask

`ifdef TL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        a_valid[1] = 1'b1; a_opcode[1] = 3'd4; a_source[1] = 8'h05;
        s_a_ready = 1'b1; d_ready[1] = 1'b0;
        tick();
        tick();
        a_valid[1] = 1'b0; s_a_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++; if ({d_valid[1], timeout_err} !== 2'b00) begin errors++; $display("FAIL to_wait%0d: got %b%b want 00", i, d_valid[1], timeout_err); end
            tick();
        end
        vectors++; if ({d_valid[1], d_valid[0], timeout_err, sd_ready} !== 4'b1010) begin errors++; $display("FAIL to_expire: got %b%b%b%b want 1010", d_valid[1], d_valid[0], timeout_err, sd_ready); end
        vectors++; if ({d_opcode[1], d_source[1], d_data[1]} !== {3'd1, 8'h05, 32'h0}) begin errors++; $display("FAIL to_fields: got %h %h %h want 1 05 0", d_opcode[1], d_source[1], d_data[1]); end
        tick();
        vectors++; if ({d_valid[1], timeout_err, busy} !== 3'b101) begin errors++; $display("FAIL to_hold: got %b%b%b want 101", d_valid[1], timeout_err, busy); end
        d_ready[1] = 1'b1;
        tick();
        s_d_valid = 1'b1;
        #1;
        vectors++; if ({busy, sd_ready, d_valid[1]} !== 3'b010) begin errors++; $display("FAIL to_done: got %b%b%b want 010", busy, sd_ready, d_valid[1]); end
        tick();
        s_d_valid = 1'b0;
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_put();
        test_arbitration();
        test_backpressure();
        test_violation();
        test_random();
`ifdef TL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end
endmodule
